// File: rtl/mpram.sv
// Multi-port single-clock RAM model with per-byte write enables, per-port read mode,
// configurable read latency and a post-reset initialisation sweep.
module mpram #(
  parameter int NUM_PORTS  = 2,
  parameter int MEM_DEPTH  = 16,
  parameter int MEM_WIDTH  = 32,
  parameter int BYTE_WIDTH = 8,
  parameter int RD_LATENCY = 1,
  parameter logic [MEM_WIDTH-1:0] INIT_VALUE = '0,
  localparam int ADDR_WIDTH = $clog2(MEM_DEPTH),
  localparam int NUM_BYTES  = MEM_WIDTH / BYTE_WIDTH
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_PORTS-1:0]              csn,
  input  logic [NUM_PORTS-1:0]              wen,
  input  logic [NUM_PORTS*NUM_BYTES-1:0]    be,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]   addr,
  input  logic [NUM_PORTS*MEM_WIDTH-1:0]    wdata,
  input  logic [NUM_PORTS-1:0]              mode,
  output logic [NUM_PORTS*MEM_WIDTH-1:0]    rdata,
  output logic [NUM_PORTS-1:0]              rvalid,
  output logic [NUM_PORTS-1:0]              collision,
  output logic                              init_busy
);

  typedef enum logic {
    ST_INIT,
    ST_READY
  } state_t;

  logic [MEM_WIDTH-1:0] mem [MEM_DEPTH];

  state_t                state;
  logic [ADDR_WIDTH-1:0] init_ptr;

  logic [NUM_PORTS-1:0]  port_act;
  logic [NUM_PORTS-1:0]  port_wr;
  logic [NUM_PORTS-1:0]  in_range;
  logic [NUM_PORTS-1:0]  coll_next;
  logic [ADDR_WIDTH-1:0] port_addr  [NUM_PORTS];
  logic [MEM_WIDTH-1:0]  port_wdata [NUM_PORTS];
  logic [NUM_BYTES-1:0]  port_be    [NUM_PORTS];
  logic [MEM_WIDTH-1:0]  rd_word    [NUM_PORTS];

  logic [NUM_PORTS-1:0]  vld_pipe  [RD_LATENCY];
  logic [NUM_PORTS-1:0]  stage_vin [RD_LATENCY];
  logic [MEM_WIDTH-1:0]  dat_pipe  [NUM_PORTS][RD_LATENCY];
  logic [MEM_WIDTH-1:0]  stage_din [NUM_PORTS][RD_LATENCY];

  // Unpack the flat port buses; inputs only matter once the sweep is done and csn is low.
  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      port_addr[p]  = addr[p*ADDR_WIDTH +: ADDR_WIDTH];
      port_wdata[p] = wdata[p*MEM_WIDTH +: MEM_WIDTH];
      port_be[p]    = be[p*NUM_BYTES +: NUM_BYTES];
      port_act[p]   = (state == ST_READY) && !csn[p];
      port_wr[p]    = port_act[p] && !wen[p];
      in_range[p]   = 32'(port_addr[p]) < MEM_DEPTH;
    end
  end

  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      rd_word[p] = '0;
      if (port_act[p] && in_range[p]) begin
        rd_word[p] = mem[port_addr[p]];
        if (port_wr[p] && mode[p]) begin
          for (int b = 0; b < NUM_BYTES; b++) begin
            if (port_be[p][b]) begin
              rd_word[p][b*BYTE_WIDTH +: BYTE_WIDTH] = port_wdata[p][b*BYTE_WIDTH +: BYTE_WIDTH];
            end
          end
        end
      end
    end
  end

  // A port loses if any of its enabled bytes overlaps an enabled byte of a lower-index writer.
  always_comb begin
    coll_next = '0;
    for (int p = 1; p < NUM_PORTS; p++) begin
      for (int q = 0; q < p; q++) begin
        if (port_wr[p] && port_wr[q] && in_range[p] && in_range[q] &&
            (port_addr[p] == port_addr[q]) && (|(port_be[p] & port_be[q]))) begin
          coll_next[p] = 1'b1;
        end
      end
    end
  end

  // Highest port is applied first so the lowest-index writer of each byte lands last and wins.
  always_ff @(posedge clk) begin
    if (state == ST_INIT) begin
      mem[init_ptr] <= INIT_VALUE;
    end else begin
      for (int p = NUM_PORTS - 1; p >= 0; p--) begin
        if (port_wr[p] && in_range[p]) begin
          for (int b = 0; b < NUM_BYTES; b++) begin
            if (port_be[p][b]) begin
              mem[port_addr[p]][b*BYTE_WIDTH +: BYTE_WIDTH] <= port_wdata[p][b*BYTE_WIDTH +: BYTE_WIDTH];
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_INIT;
      init_ptr  <= '0;
      init_busy <= 1'b1;
      collision <= '0;
    end else begin
      collision <= coll_next;
      case (state)
        ST_INIT: begin
          if (init_ptr == ADDR_WIDTH'(MEM_DEPTH - 1)) begin
            state     <= ST_READY;
            init_busy <= 1'b0;
          end else begin
            init_ptr <= init_ptr + 1'b1;
          end
        end
        ST_READY: begin
          state <= ST_READY;
        end
        default: begin
          state <= ST_INIT;
        end
      endcase
    end
  end

  always_comb begin
    stage_vin[0] = port_act;
    for (int i = 1; i < RD_LATENCY; i++) begin
      stage_vin[i] = vld_pipe[i-1];
    end
    for (int p = 0; p < NUM_PORTS; p++) begin
      stage_din[p][0] = rd_word[p];
      for (int i = 1; i < RD_LATENCY; i++) begin
        stage_din[p][i] = dat_pipe[p][i-1];
      end
    end
  end

  // The final stage doubles as the rdata register, so it only loads on a valid beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RD_LATENCY; i++) begin
        vld_pipe[i] <= '0;
      end
      for (int p = 0; p < NUM_PORTS; p++) begin
        for (int i = 0; i < RD_LATENCY; i++) begin
          dat_pipe[p][i] <= '0;
        end
      end
    end else begin
      for (int i = 0; i < RD_LATENCY; i++) begin
        vld_pipe[i] <= stage_vin[i];
      end
      for (int p = 0; p < NUM_PORTS; p++) begin
        for (int i = 0; i < RD_LATENCY; i++) begin
          if ((i < RD_LATENCY - 1) || stage_vin[i][p]) begin
            dat_pipe[p][i] <= stage_din[p][i];
          end
        end
      end
    end
  end

  always_comb begin
    rvalid = vld_pipe[RD_LATENCY-1];
    for (int p = 0; p < NUM_PORTS; p++) begin
      rdata[p*MEM_WIDTH +: MEM_WIDTH] = dat_pipe[p][RD_LATENCY-1];
    end
  end

endmodule

// File: tb/tb_mpram.sv
// Directed bench for mpram: a default instance plus a 12-word, 3-cycle-latency instance
// driven by the same stimulus.
module tb_mpram;

  logic        clk;
  logic        rst;
  logic [1:0]  csn;
  logic [1:0]  wen;
  logic [7:0]  be;
  logic [7:0]  addr;
  logic [63:0] wdata;
  logic [1:0]  mode;

  logic [63:0] rdata;
  logic [1:0]  rvalid;
  logic [1:0]  collision;
  logic        init_busy;

  logic [63:0] rdata_l;
  logic [1:0]  rvalid_l;
  logic [1:0]  collision_l;
  logic        init_busy_l;

  int check_cnt = 0;
  int pass_cnt  = 0;

  mpram u_dut (
    .clk       (clk),
    .rst       (rst),
    .csn       (csn),
    .wen       (wen),
    .be        (be),
    .addr      (addr),
    .wdata     (wdata),
    .mode      (mode),
    .rdata     (rdata),
    .rvalid    (rvalid),
    .collision (collision),
    .init_busy (init_busy)
  );

  mpram #(.MEM_DEPTH(12), .RD_LATENCY(3)) u_lat (
    .clk       (clk),
    .rst       (rst),
    .csn       (csn),
    .wen       (wen),
    .be        (be),
    .addr      (addr),
    .wdata     (wdata),
    .mode      (mode),
    .rdata     (rdata_l),
    .rvalid    (rvalid_l),
    .collision (collision_l),
    .init_busy (init_busy_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Inactive ports carry junk to show it has no effect.
  task automatic idle();
    csn   = 2'b11;
    wen   = 2'b11;
    mode  = 2'b00;
    be    = 8'h5A;
    addr  = 8'hF3;
    wdata = 64'hDEAD_0BAD_CAFE_F00D;
  endtask

  task automatic drive(input int p, input logic wr, input logic md, input logic [3:0] b,
                       input logic [3:0] a, input logic [31:0] d);
    csn[p]          = 1'b0;
    wen[p]          = ~wr;
    mode[p]         = md;
    be[p*4 +: 4]    = b;
    addr[p*4 +: 4]  = a;
    wdata[p*32 +: 32] = d;
  endtask

  task automatic count_init(input int exp_cycles, input string name);
    int n = 0;
    int n_lat = 0;
    logic leaked = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      n++;
      if (rvalid !== 2'b00) leaked = 1'b1;
      if (init_busy_l === 1'b0 && n_lat == 0) n_lat = n;
      if (init_busy === 1'b0) break;
    end
    check_cnt++;
    if (n !== exp_cycles) $display("[TB] FAIL %s_busy_cycles: got %0d expected %0d", name, n, exp_cycles);
    else pass_cnt++;
    check_cnt++;
    if (leaked !== 1'b0) $display("[TB] FAIL %s_no_access_in_init: got rvalid during init expected none", name);
    else pass_cnt++;
    check_cnt++;
    if (n_lat !== 12) $display("[TB] FAIL %s_busy_cycles_depth12: got %0d expected 12", name, n_lat);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    repeat (3) tick();
    check_cnt++;
    if ({init_busy, rvalid, collision, rdata} !== {1'b1, 2'b00, 2'b00, 64'h0})
      $display("[TB] FAIL reset_state: got busy=%b rvalid=%b coll=%b rdata=%h expected 1 00 00 0",
               init_busy, rvalid, collision, rdata);
    else pass_cnt++;
    check_cnt++;
    if ({init_busy_l, rvalid_l} !== {1'b1, 2'b00})
      $display("[TB] FAIL reset_state_lat: got busy=%b rvalid=%b expected 1 00", init_busy_l, rvalid_l);
    else pass_cnt++;
    rst = 1'b0;
    csn = 2'b00;
    count_init(16, "init");
    idle();
  endtask

  task automatic test_init_read();
    for (int i = 0; i < 16; i++) begin
      idle();
      drive(0, 1'b0, 1'b0, 4'hF, 4'(i), 32'h0BAD_0BAD);
      drive(1, 1'b0, 1'b0, 4'hF, 4'(15 - i), 32'h0BAD_0BAD);
      tick();
      check_cnt++;
      if ({rvalid, rdata} !== {2'b11, 64'h0})
        $display("[TB] FAIL init_read_%0d: got rvalid=%b rdata=%h expected 11 0", i, rvalid, rdata);
      else pass_cnt++;
    end
    idle();
    tick();
    check_cnt++;
    if (rvalid !== 2'b00) $display("[TB] FAIL init_read_no_trailing_valid: got %b expected 00", rvalid);
    else pass_cnt++;
  endtask

  task automatic test_byte_write();
    idle();
    drive(0, 1'b1, 1'b0, 4'hF, 4'd5, 32'hAABBCCDD);
    tick();
    idle();
    drive(0, 1'b1, 1'b0, 4'b0101, 4'd5, 32'h11223344);
    tick();
    idle();
    drive(1, 1'b0, 1'b0, 4'hF, 4'd5, 32'h0);
    tick();
    check_cnt++;
    if ({rvalid[1], rdata[63:32]} !== {1'b1, 32'hAA22CC44})
      $display("[TB] FAIL byte_write: got v=%b %h expected 1 aa22cc44", rvalid[1], rdata[63:32]);
    else pass_cnt++;
  endtask

  task automatic test_modes();
    idle();
    drive(0, 1'b1, 1'b0, 4'hF, 4'd3, 32'hDEADBEEF);
    drive(1, 1'b0, 1'b0, 4'hF, 4'd3, 32'h0);
    tick();
    check_cnt++;
    if ({rvalid, rdata} !== {2'b11, 64'h0})
      $display("[TB] FAIL read_first: got v=%b %h expected 11 0", rvalid, rdata);
    else pass_cnt++;
    idle();
    drive(0, 1'b1, 1'b1, 4'hF, 4'd3, 32'h12345678);
    drive(1, 1'b0, 1'b0, 4'hF, 4'd3, 32'h0);
    tick();
    check_cnt++;
    if (rdata !== {32'hDEADBEEF, 32'h12345678})
      $display("[TB] FAIL write_first_full: got %h expected deadbeef12345678", rdata);
    else pass_cnt++;
    idle();
    drive(0, 1'b1, 1'b1, 4'b0101, 4'd3, 32'hAABBCCDD);
    drive(1, 1'b0, 1'b0, 4'hF, 4'd3, 32'h0);
    tick();
    check_cnt++;
    if (rdata !== {32'h12345678, 32'h12BB56DD})
      $display("[TB] FAIL write_first_partial: got %h expected 1234567812bb56dd", rdata);
    else pass_cnt++;
    idle();
    drive(1, 1'b0, 1'b0, 4'hF, 4'd3, 32'h0);
    tick();
    check_cnt++;
    if (rdata[63:32] !== 32'h12BB56DD)
      $display("[TB] FAIL write_visible_next: got %h expected 12bb56dd", rdata[63:32]);
    else pass_cnt++;
  endtask

  task automatic test_collision();
    idle();
    drive(0, 1'b1, 1'b0, 4'hF, 4'd7, 32'h1);
    drive(1, 1'b1, 1'b0, 4'hF, 4'd7, 32'h2);
    tick();
    check_cnt++;
    if (collision !== 2'b10) $display("[TB] FAIL collision_full: got %b expected 10", collision);
    else pass_cnt++;
    idle();
    drive(0, 1'b0, 1'b0, 4'hF, 4'd7, 32'h0);
    tick();
    check_cnt++;
    if ({collision, rdata[31:0]} !== {2'b00, 32'h1})
      $display("[TB] FAIL collision_pulse_winner: got coll=%b %h expected 00 1", collision, rdata[31:0]);
    else pass_cnt++;
    idle();
    drive(0, 1'b1, 1'b0, 4'h3, 4'd7, 32'hAAAA5555);
    drive(1, 1'b1, 1'b0, 4'hC, 4'd7, 32'h77778888);
    tick();
    check_cnt++;
    if (collision !== 2'b00) $display("[TB] FAIL collision_disjoint: got %b expected 00", collision);
    else pass_cnt++;
    idle();
    drive(1, 1'b0, 1'b0, 4'hF, 4'd7, 32'h0);
    tick();
    check_cnt++;
    if (rdata[63:32] !== 32'h77775555) $display("[TB] FAIL disjoint_merge: got %h expected 77775555", rdata[63:32]);
    else pass_cnt++;
    idle();
    drive(0, 1'b1, 1'b0, 4'b0011, 4'd7, 32'h11111111);
    drive(1, 1'b1, 1'b0, 4'b0110, 4'd7, 32'h22222222);
    tick();
    check_cnt++;
    if (collision !== 2'b10) $display("[TB] FAIL collision_partial: got %b expected 10", collision);
    else pass_cnt++;
    idle();
    drive(0, 1'b0, 1'b0, 4'hF, 4'd7, 32'h0);
    tick();
    check_cnt++;
    if (rdata[31:0] !== 32'h77221111) $display("[TB] FAIL partial_byte_resolve: got %h expected 77221111", rdata[31:0]);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [3:0]  adrs [3] = '{4'd5, 4'd3, 4'd7};
    logic [31:0] exps [3] = '{32'hAA22CC44, 32'h12BB56DD, 32'h77221111};
    for (int i = 0; i < 3; i++) begin
      idle();
      drive(1, 1'b0, 1'b0, 4'hF, adrs[i], 32'h0);
      tick();
      check_cnt++;
      if ({rvalid, rdata[63:32]} !== {2'b10, exps[i]})
        $display("[TB] FAIL back_to_back_%0d: got v=%b %h expected 10 %h", i, rvalid, rdata[63:32], exps[i]);
      else pass_cnt++;
    end
    idle();
    tick();
    check_cnt++;
    if ({rvalid, rdata[63:32]} !== {2'b00, 32'h77221111})
      $display("[TB] FAIL rdata_hold: got v=%b %h expected 00 77221111", rvalid, rdata[63:32]);
    else pass_cnt++;
  endtask

  task automatic test_latency();
    logic        exp_v [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [31:0] exp_d [6] = '{32'h0, 32'h0, 32'h100, 32'h101, 32'h102, 32'h102};
    for (int i = 0; i < 3; i++) begin
      idle();
      drive(0, 1'b1, 1'b0, 4'hF, 4'(i), 32'h100 + 32'(i));
      tick();
    end
    idle();
    repeat (3) tick();
    for (int k = 0; k < 6; k++) begin
      idle();
      if (k < 3) drive(0, 1'b0, 1'b0, 4'hF, 4'(k), 32'h0);
      tick();
      check_cnt++;
      if ({rvalid_l[0], rdata_l[31:0]} !== {exp_v[k], exp_d[k]})
        $display("[TB] FAIL latency3_cycle%0d: got v=%b %h expected %b %h",
                 k + 1, rvalid_l[0], rdata_l[31:0], exp_v[k], exp_d[k]);
      else pass_cnt++;
    end
    idle();
    drive(0, 1'b0, 1'b0, 4'hF, 4'd13, 32'h0);
    tick();
    idle();
    tick();
    tick();
    check_cnt++;
    if ({rvalid_l[0], rdata_l[31:0]} !== {1'b1, 32'h0})
      $display("[TB] FAIL out_of_range_read: got v=%b %h expected 1 0", rvalid_l[0], rdata_l[31:0]);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    idle();
    drive(0, 1'b0, 1'b0, 4'hF, 4'd1, 32'h0);
    tick();
    idle();
    drive(0, 1'b0, 1'b0, 4'hF, 4'd2, 32'h0);
    tick();
    check_cnt++;
    if (rdata[31:0] !== 32'h102) $display("[TB] FAIL pre_reset_read: got %h expected 102", rdata[31:0]);
    else pass_cnt++;
    idle();
    rst = 1'b1;
    #1;
    check_cnt++;
    if ({rvalid, rdata, init_busy, rvalid_l, rdata_l, init_busy_l} !== {2'b00, 64'h0, 1'b1, 2'b00, 64'h0, 1'b1})
      $display("[TB] FAIL async_reset_ready: got v=%b d=%h b=%b vl=%b dl=%h bl=%b expected all cleared, busy 1",
               rvalid, rdata, init_busy, rvalid_l, rdata_l, init_busy_l);
    else pass_cnt++;
    tick();
    tick();
    rst = 1'b0;
    repeat (8) tick();
    rst = 1'b1;
    #1;
    check_cnt++;
    if (init_busy !== 1'b1) $display("[TB] FAIL reset_mid_init_busy: got %b expected 1", init_busy);
    else pass_cnt++;
    tick();
    rst = 1'b0;
    count_init(16, "reinit");
    idle();
    drive(0, 1'b0, 1'b0, 4'hF, 4'd1, 32'h0);
    drive(1, 1'b0, 1'b0, 4'hF, 4'd5, 32'h0);
    tick();
    check_cnt++;
    if ({rvalid, rdata} !== {2'b11, 64'h0})
      $display("[TB] FAIL reinit_contents: got v=%b %h expected 11 0", rvalid, rdata);
    else pass_cnt++;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    test_reset();
    test_init_read();
    test_byte_write();
    test_modes();
    test_collision();
    test_back_to_back();
    test_latency();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule

// File: doc/mpram.md
Name: mpram

Overview:
Parameterised multi-port, single-clock RAM model with per-byte write enables, per-port read-first/write-first mode and a configurable registered read latency. It generalises the team's dual-port model to NUM_PORTS ports and adds a post-reset initialisation sequencer. Same-address write collisions are resolved deterministically and flagged. It is used as the on-chip storage model behind buffers and register files in block-level simulation.

Parameters:
NUM_PORTS, 2, number of independent read/write ports (>=1)
MEM_DEPTH, 16, number of words (>=2)
MEM_WIDTH, 32, word width in bits; must be a multiple of BYTE_WIDTH
BYTE_WIDTH, 8, write-enable granularity in bits
RD_LATENCY, 1, cycles from accepted access to rvalid/rdata (1..4)
INIT_VALUE, 0, value written to every word by the init sequencer
(derived) ADDR_WIDTH = $clog2(MEM_DEPTH); NUM_BYTES = MEM_WIDTH/BYTE_WIDTH

Ports:
clk  input  1  single clock, all state on posedge
rst  input  1  asynchronous, active-high reset
csn  input  NUM_PORTS  per-port chip select, active low
wen  input  NUM_PORTS  per-port write enable, active low (qualified by csn)
be  input  NUM_PORTS*NUM_BYTES  per-port byte enables, active high; port p occupies bits [p*NUM_BYTES +: NUM_BYTES]
addr  input  NUM_PORTS*ADDR_WIDTH  per-port word address, packed as above
wdata  input  NUM_PORTS*MEM_WIDTH  per-port write data, packed as above
mode  input  NUM_PORTS  per-port write-cycle read mode; 0 = read-first, 1 = write-first
rdata  output  NUM_PORTS*MEM_WIDTH  per-port read data, packed as above
rvalid  output  NUM_PORTS  per-port read-data-valid pulse
collision  output  NUM_PORTS  per-port "write lost" flag, 1-cycle pulse
init_busy  output  1  high while reset or init sequence in progress; accesses ignored

Behaviour:
- Reset (rst=1, async): rdata=0, rvalid=0, collision=0, init_busy=1, all latency pipeline stages cleared, FSM=INIT, init pointer=0. Memory array is not cleared combinationally.
- FSM INIT: on each clk after rst deasserts, write INIT_VALUE to mem[ptr] and increment ptr. After writing MEM_DEPTH-1, go to READY. init_busy falls on the edge that enters READY, so it is high for exactly MEM_DEPTH cycles after reset release. rst asserted mid-INIT restarts at ptr=0.
- In INIT, all port inputs are ignored: no writes, no rvalid, no collision.
- READY: port p is active when ~csn[p]. Its access is a write when ~wen[p] as well.
- Write: at posedge, byte b of mem[addr_p] takes wdata_p byte b where be_p[b]=1; the other bytes are unchanged. A write with be=0 performs no update but still counts as an access.
- Read data: every active access, read or write, produces rvalid[p]=1 exactly RD_LATENCY cycles later with the corresponding rdata_p. Back-to-back accesses give back-to-back valids with no bubbles.
  - Pure read: returns the pre-edge mem[addr_p].
  - Write, mode=0: returns the pre-edge word.
  - Write, mode=1: returns the pre-edge word with port p's enabled bytes replaced by wdata_p.
- Cross-port visibility: a read on port q in the same cycle as a write on port p (p!=q) to the same address returns pre-edge content. The written data is visible to reads issued on the next cycle.
- Write-write collision: when several ports write the same address in one cycle, each byte is resolved independently. The lowest-index port with that byte enabled wins. collision[p] pulses the next cycle for every port p that had at least one enabled byte overwritten by a lower-index port. Disjoint byte enables do not collide.
- rdata_p holds its last value while rvalid[p]=0. There is no tri-state.
- Out-of-range addresses (>= MEM_DEPTH when not a power of 2): the write is dropped, the read returns 0, and rvalid is still generated.
- Address, data and be are sampled only when the port is active. X on inactive ports has no effect.

Test Plan:
- Init: pulse rst 3 cycles, release -> init_busy high 16 cycles then 0; read addr 0..15 -> all rdata=0x00000000, rvalid 1 cycle after each access.
- Byte write: port0 writes addr 5 = 0xAABBCCDD with be=4'hF, then addr 5 = 0x11223344 with be=4'b0101; read port1 addr 5 -> 0xAA22CC44.
- Modes: mem[3]=0x0; port0 write 0xDEADBEEF to addr 3 with mode=0 -> rdata0=0x00000000; repeat write 0x12345678 with mode=1 -> rdata0=0x12345678. Same cycle port1 reads addr 3 -> pre-edge value.
- Collision: both ports write addr 7 be=4'hF, port0=0x1, port1=0x2 -> mem[7]=0x1, collision=2'b10 for one cycle. Repeat with be0=4'h3, be1=4'hC -> both bytes kept, collision=0.
- Latency: RD_LATENCY=3, port0 reads addr 0,1,2 on consecutive cycles -> rvalid0 high cycles 3,4,5 with matching data in order.
- Reset mid-operation: assert rst during INIT (ptr=8) and during READY with reads in flight -> rvalid/rdata drop to 0 immediately; init restarts from 0 and takes 16 cycles.
